core_control_wb_arbiter: RTL and testbench
==========================================

# core_control_wb_arbiter

Shares the single register-file write port between the ALU writeback path and the load/store (memory) writeback path, and keeps a per-register pending scoreboard for the issue/stall logic. Memory results cannot be back-pressured and always win the port. Colliding ALU results are deferred in a small FIFO. The `pending` mask feeds the hazard checks in `core_control`, replacing the single-destination `final_rd` comparison with a full in-flight view.

## Interface
Parameters:
- `DEPTH`, default 2: ALU deferral FIFO depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  core clock; every register updates on its rising edge
- `rst`  in  1  synchronous reset, active-high
- `issue_valid`  in  1  an instruction with a register writeback issues this cycle
- `issue_rd`  in  4  destination register of that instruction
- `alu_valid`  in  1  ALU result offered
- `alu_rd`  in  4  ALU destination register
- `alu_value`  in  32  ALU result
- `alu_ready`  out  1  ALU result accepted this cycle
- `mem_valid`  in  1  load data returned; must be accepted unconditionally
- `mem_rd`  in  4  load destination register
- `mem_value`  in  32  load data
- `wr_en`  out  1  register-file write strobe, registered
- `wr_rd`  out  4  register-file write address, registered
- `wr_value`  out  32  register-file write data, registered
- `pending`  out  16  bit r set while a write to register r is in flight
- `pc_pending`  out  1  equals `pending[15]`
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `error`  out  1  sticky protocol-violation flag

## Operation
- Reset values: `wr_en`=0, `wr_rd`=0, `wr_value`=0, `pending`=0, `fifo_count`=0, `error`=0. FIFO pointers are cleared. Reset applies from any state and discards queued entries.
- `alu_ready` = `fifo_count` < DEPTH. It is combinational, with no dependency on `alu_valid`.
- Port source selection, evaluated each cycle in priority order:
  1. `mem_valid`: load `wr_*` from mem.
  2. Else, FIFO non-empty: pop the head into `wr_*`.
  3. Else, `alu_valid`: load `wr_*` directly from the ALU (bypass).
  4. Else: `wr_en` ← 0.
- FIFO push: an accepted ALU result (`alu_valid && alu_ready`) is pushed when it does not win the port, i.e. when `mem_valid` is set or the FIFO is non-empty. A pop and a push in the same cycle leave `fifo_count` unchanged.
- Order guarantees:
  - ALU results commit in acceptance order.
  - Memory results may overtake queued ALU results. This is legal because at most one writer per register is in flight.
- Scoreboard:
  - At the clock edge, `issue_valid` sets `pending[issue_rd]`.
  - At the clock edge, `wr_en` high clears `pending[wr_rd]`. The bit therefore drops the cycle after the register-file write, when the new value is readable.
  - Set and clear of the same register on the same edge: set wins.
- `error` sets and holds until `rst` on any of:
  - `issue_valid` for a register already pending without a same-edge clear;
  - `mem_valid` or accepted `alu_valid` for a register whose pending bit is 0;
  - `alu_valid` with `alu_ready` low. The ALU holds its result; this is not an error.

  Correction: the third case is not an error. Only the first two set `error`.

## Timing
- Bypass latency: ALU accepted in cycle N → `wr_en`=1 in N+1 → `pending` bit clear in N+2.
- Memory latency is the same as bypass. Memory is never delayed.
- A queued ALU entry waits one cycle per preceding FIFO entry plus one cycle per cycle with `mem_valid` high.
- FIFO full: `alu_ready`=0 in the same cycle `fifo_count`==DEPTH. A pop in that cycle does not raise `alu_ready` until the next cycle, so there is no combinational ready-through-pop path.
- Throughput: one port write per cycle. Sustained back-to-back `mem_valid` starves the FIFO, which is acceptable because the load/store unit is bounded.

## Structure
- `reg_num` and `word` come from the shared uarch package.
- Add to that package:
  - `wb_entry` struct {`reg_num rd`; `word value`};
  - `` `R15 `` usage for `pc_pending`.
- One sub-module: `core_control_wb_fifo` (parameterised DEPTH, `wb_entry` payload, push/pop/count, synchronous `rst`). Arbitration and scoreboard logic live in the top.

## Test plan
- Reset, then issue r3 and ALU r3=0x11 alone → `wr_en`, rd=3, value=0x11 one cycle later; `pending[3]` drops the following cycle; `fifo_count` stays 0.
- Same cycle: mem r5=0xAA and ALU r6=0xBB → cycle+1 writes r5; cycle+2 writes r6 from the FIFO; `fifo_count` goes 1 then 0.
- `mem_valid` held 4 cycles while ALU offers r1, r2, r4 each cycle (DEPTH=2) → `alu_ready` drops on the third offer; commits are mem×4, then r1, then r2, then r4.
- Issue r7 and commit r7 on the same edge → `pending[7]` remains 1. Issue r7 again with no clear → `error`=1 and stays 1.
- Issue r15, then ALU r15 → `pc_pending` high from issue until two cycles after ALU acceptance.
- Assert `rst` with two FIFO entries and pending bits set → the next cycle shows all outputs at reset values and no further writes.

Source files
------------

// File: rtl/core_control_wb_arbiter_pkg.sv
// Shared micro-architecture types for the writeback arbiter: register
// numbers, data words, the queued writeback entry and a one-hot helper.
package core_control_wb_arbiter_pkg;

  typedef logic [3:0]  reg_num;
  typedef logic [31:0] word;

  // One deferred ALU writeback: destination register and its result.
  typedef struct packed {
    reg_num rd;
    word    value;
  } wb_entry;

  // The program counter lives in r15; its pending bit is exported separately.
  localparam reg_num R15 = 4'd15;

  // One-hot mask selecting a single register of the pending scoreboard.
  function automatic logic [15:0] reg_onehot(input reg_num r);
    return 16'(1) << r;
  endfunction

endpackage

// File: rtl/core_control_wb_fifo.sv
// Small circular FIFO holding ALU writebacks that lost the register-file
// write port. The caller guarantees no push when full and no pop when empty.
module core_control_wb_fifo
  import core_control_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  wb_entry                  i_push_data,
  input  logic                     i_pop,
  output wb_entry                  o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/core_control_wb_arbiter.sv
// Register-file write-port arbiter between the memory (load) and ALU
// writeback paths, plus a per-register pending scoreboard for hazard checks.
//
// Handshake: the ALU result transfers on a clock edge where alu_valid and
// alu_ready are both high. alu_ready depends only on the FIFO occupancy
// (never on alu_valid or on a same-cycle pop); while alu_ready is low the
// ALU holds its result stable. The memory path has no ready: a mem_valid
// cycle is always consumed and always owns the port.
module core_control_wb_arbiter
  import core_control_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [3:0]              issue_rd,
  input  logic                    alu_valid,
  input  logic [3:0]              alu_rd,
  input  logic [31:0]             alu_value,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [3:0]              mem_rd,
  input  logic [31:0]             mem_value,
  output logic                    wr_en,
  output logic [3:0]              wr_rd,
  output logic [31:0]             wr_value,
  output logic [15:0]             pending,
  output logic                    pc_pending,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    error
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_alu_ready;
  logic          w_alu_acc;
  logic          w_push;
  logic          w_pop;
  wb_entry       w_head;
  wb_entry       w_alu_entry;

  logic          w_nxt_en;
  reg_num        w_nxt_rd;
  word           w_nxt_value;

  logic [15:0]   w_set;
  logic [15:0]   w_clr;
  logic [15:0]   w_pending_nxt;
  logic          w_err_now;

  logic          r_wr_en;
  reg_num        r_wr_rd;
  word           r_wr_value;
  logic [15:0]   r_pending;
  logic          r_error;

  assign w_empty     = (w_count == '0);
  assign w_alu_ready = (w_count < CW'(DEPTH));
  assign w_alu_acc   = alu_valid && w_alu_ready;
  // An accepted ALU result is deferred whenever something else owns the port.
  assign w_push      = w_alu_acc && (mem_valid || !w_empty);
  assign w_pop       = !mem_valid && !w_empty;
  assign w_alu_entry = '{rd: alu_rd, value: alu_value};

  core_control_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_alu_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Port source priority: memory, then oldest queued ALU result, then bypass.
  always_comb begin
    w_nxt_en    = 1'b0;
    w_nxt_rd    = r_wr_rd;
    w_nxt_value = r_wr_value;
    if (mem_valid) begin
      w_nxt_en    = 1'b1;
      w_nxt_rd    = mem_rd;
      w_nxt_value = mem_value;
    end else if (!w_empty) begin
      w_nxt_en    = 1'b1;
      w_nxt_rd    = w_head.rd;
      w_nxt_value = w_head.value;
    end else if (alu_valid) begin
      w_nxt_en    = 1'b1;
      w_nxt_rd    = alu_rd;
      w_nxt_value = alu_value;
    end
  end

  // Scoreboard update (set beats clear) and protocol-violation detection.
  always_comb begin
    w_set         = issue_valid ? reg_onehot(issue_rd) : 16'h0000;
    w_clr         = r_wr_en ? reg_onehot(r_wr_rd) : 16'h0000;
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
    w_err_now     = 1'b0;
    if (issue_valid && r_pending[issue_rd] && !(r_wr_en && (r_wr_rd == issue_rd)))
      w_err_now = 1'b1;
    if (mem_valid && !r_pending[mem_rd])
      w_err_now = 1'b1;
    if (w_alu_acc && !r_pending[alu_rd])
      w_err_now = 1'b1;
  end

  // Registered write port, scoreboard and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_rd    <= '0;
      r_wr_value <= '0;
      r_pending  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_wr_en    <= w_nxt_en;
      r_wr_rd    <= w_nxt_rd;
      r_wr_value <= w_nxt_value;
      r_pending  <= w_pending_nxt;
      r_error    <= r_error | w_err_now;
    end
  end

  assign alu_ready  = w_alu_ready;
  assign wr_en      = r_wr_en;
  assign wr_rd      = r_wr_rd;
  assign wr_value   = r_wr_value;
  assign pending    = r_pending;
  assign pc_pending = r_pending[R15];
  assign fifo_count = w_count;
  assign error      = r_error;

endmodule

// File: tb/tb_core_control_wb_arbiter.sv
// Directed bench for the writeback arbiter: linear stimulus, hand-computed
// expectations, immediate assertions at every comparison point.
module tb_core_control_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [31:0] mem_value;
  logic        wr_en;
  logic [3:0]  wr_rd;
  logic [31:0] wr_value;
  logic [15:0] pending;
  logic        pc_pending;
  logic [1:0]  fifo_count;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  // Phase-3 table: mem held four cycles while the ALU offers r1, r2, r4.
  int t3_mem_v [7] = '{1, 1, 1, 1, 0, 0, 0};
  int t3_alu_v [7] = '{1, 1, 1, 1, 1, 1, 0};
  int t3_alu_rd[7] = '{1, 2, 4, 4, 4, 4, 0};
  int t3_rdy   [7] = '{1, 1, 0, 0, 0, 1, 1};
  int t3_wr_rd [7] = '{8, 9, 10, 11, 1, 2, 4};
  int t3_wr_val[7] = '{'h108, 'h109, 'h10A, 'h10B, 'h1, 'h2, 'h4};
  int t3_cnt   [7] = '{1, 2, 2, 2, 1, 1, 0};
  int t3_issue [7] = '{1, 2, 4, 8, 9, 10, 11};

  core_control_wb_arbiter #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_value   (alu_value),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_value   (mem_value),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_value    (wr_value),
    .pending     (pending),
    .pc_pending  (pc_pending),
    .fifo_count  (fifo_count),
    .error       (error)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd  = '0;
    alu_valid   = 1'b0; alu_rd    = '0; alu_value = '0;
    mem_valid   = 1'b0; mem_rd    = '0; mem_value = '0;
  endtask

  task automatic issue(input logic [3:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
  endtask

  task automatic wr_chk(input string tag, input logic en, input logic [3:0] rd,
                        input logic [31:0] val, input logic [1:0] cnt);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(en));
    if (en) begin
      chk({tag, "_wr_rd"}, 32'(wr_rd), 32'(rd));
      chk({tag, "_wr_value"}, wr_value, val);
    end
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'(cnt));
  endtask

  initial begin
    // Reset
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_rd", 32'(wr_rd), 0);
    chk("rst_wr_value", wr_value, 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_alu_ready", 32'(alu_ready), 1);

    // Bypass: issue r3, then ALU r3=0x11 alone
    issue(4'd3);
    chk("byp_pend_set", 32'(pending), 32'h0008);
    idle();
    alu_valid = 1'b1; alu_rd = 4'd3; alu_value = 32'h11;
    #1 chk("byp_ready", 32'(alu_ready), 1);
    tick();
    wr_chk("byp_commit", 1'b1, 4'd3, 32'h11, 2'd0);
    chk("byp_pend_still", 32'(pending), 32'h0008);
    idle();
    tick();
    wr_chk("byp_idle", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("byp_pend_clr", 32'(pending), 32'h0000);

    // Collision: mem r5=0xAA and ALU r6=0xBB in the same cycle
    issue(4'd5);
    issue(4'd6);
    idle();
    mem_valid = 1'b1; mem_rd = 4'd5; mem_value = 32'hAA;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_value = 32'hBB;
    tick();
    wr_chk("col_mem", 1'b1, 4'd5, 32'hAA, 2'd1);
    chk("col_pend1", 32'(pending), 32'h0060);
    idle();
    tick();
    wr_chk("col_pop", 1'b1, 4'd6, 32'hBB, 2'd0);
    chk("col_pend2", 32'(pending), 32'h0040);
    idle();
    tick();
    wr_chk("col_idle", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("col_pend3", 32'(pending), 32'h0000);

    // FIFO fill under sustained memory traffic
    for (int i = 0; i < 7; i++) issue(4'(t3_issue[i]));
    chk("fill_pend_set", 32'(pending), 32'h0F16);
    for (int i = 0; i < 7; i++) begin
      idle();
      mem_valid = 1'(t3_mem_v[i]);
      mem_rd    = 4'(8 + i);
      mem_value = 32'(32'h108 + i);
      alu_valid = 1'(t3_alu_v[i]);
      alu_rd    = 4'(t3_alu_rd[i]);
      alu_value = 32'(t3_alu_rd[i]);
      #1 chk($sformatf("fill_ready_c%0d", i), 32'(alu_ready), 32'(t3_rdy[i]));
      tick();
      wr_chk($sformatf("fill_c%0d", i), 1'b1, 4'(t3_wr_rd[i]), 32'(t3_wr_val[i]),
             2'(t3_cnt[i]));
    end
    idle();
    tick();
    wr_chk("fill_idle", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("fill_pend_clr", 32'(pending), 32'h0000);
    chk("fill_error", 32'(error), 0);

    // Program counter pending
    issue(4'd15);
    chk("pc_after_issue", 32'(pc_pending), 1);
    idle();
    alu_valid = 1'b1; alu_rd = 4'd15; alu_value = 32'hF0;
    tick();
    wr_chk("pc_commit", 1'b1, 4'd15, 32'hF0, 2'd0);
    chk("pc_during_write", 32'(pc_pending), 1);
    idle();
    tick();
    chk("pc_cleared", 32'(pc_pending), 0);

    // Same-edge set and clear, then a true double issue
    issue(4'd7);
    idle();
    alu_valid = 1'b1; alu_rd = 4'd7; alu_value = 32'h77;
    tick();
    wr_chk("r7_commit", 1'b1, 4'd7, 32'h77, 2'd0);
    issue(4'd7);
    chk("r7_set_wins", 32'(pending), 32'h0080);
    chk("r7_no_error", 32'(error), 0);
    issue(4'd7);
    chk("r7_dbl_error", 32'(error), 1);
    idle();
    tick(); tick();
    chk("r7_error_sticky", 32'(error), 1);

    // Reset with two queued entries and pending bits set
    issue(4'd1);
    issue(4'd2);
    issue(4'd3);
    issue(4'd4);
    idle();
    mem_valid = 1'b1; mem_rd = 4'd1; mem_value = 32'h5;
    alu_valid = 1'b1; alu_rd = 4'd2; alu_value = 32'h6;
    tick();
    wr_chk("prerst_a", 1'b1, 4'd1, 32'h5, 2'd1);
    idle();
    mem_valid = 1'b1; mem_rd = 4'd4; mem_value = 32'h8;
    alu_valid = 1'b1; alu_rd = 4'd3; alu_value = 32'h7;
    tick();
    wr_chk("prerst_b", 1'b1, 4'd4, 32'h8, 2'd2);
    chk("prerst_ready", 32'(alu_ready), 0);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_chk("rst2", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("rst2_wr_rd", 32'(wr_rd), 0);
    chk("rst2_wr_value", wr_value, 0);
    chk("rst2_pending", 32'(pending), 0);
    chk("rst2_pc_pending", 32'(pc_pending), 0);
    chk("rst2_error", 32'(error), 0);
    chk("rst2_ready", 32'(alu_ready), 1);
    tick();
    wr_chk("post_rst1", 1'b0, 4'd0, 32'h0, 2'd0);
    tick();
    wr_chk("post_rst2", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("post_rst_pending", 32'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
